// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution frame sequencer.
package conv_pkg;

    localparam int unsigned KERNEL_TAPS  = 9;
    localparam int unsigned WEIGHT_WIDTH = 32;
    localparam int unsigned KERNEL_BUS_W = KERNEL_TAPS * WEIGHT_WIDTH;
    localparam int unsigned WADDR_W      = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } seq_state_e;

    function automatic int unsigned pix_total(input int unsigned h, input int unsigned w);
        return h * w;
    endfunction

    // A 3x3 valid convolution trims one pixel from every border.
    function automatic int unsigned res_total(input int unsigned h, input int unsigned w);
        return (h - 2) * (w - 2);
    endfunction

endpackage

// File: rtl/conv_weight_bank.sv
// Nine-entry kernel weight register file with per-entry loaded mask and flat bus view.
module conv_weight_bank
    import conv_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [WADDR_W-1:0]      wr_addr,
    input  logic [WEIGHT_WIDTH-1:0] wr_data,
    output logic [KERNEL_BUS_W-1:0] kernel_bus,
    output logic [KERNEL_TAPS-1:0]  mask,
    output logic                    addr_ok_c
);

    assign addr_ok_c = (wr_addr < WADDR_W'(KERNEL_TAPS));

    always_ff @(posedge clk) begin
        if (rst) begin
            kernel_bus <= '0;
            mask       <= '0;
        end else if (wr_en && addr_ok_c) begin
            kernel_bus[wr_addr*WEIGHT_WIDTH +: WEIGHT_WIDTH] <= wr_data;
            mask[wr_addr]                                    <= 1'b1;
        end
    end

endmodule

// File: rtl/conv3x3_frame_sequencer.sv
// Frame sequencer for a 3x3 stride-1 convolution engine: weight bank, pixel streaming, result counting.
// Optional cycle/stall performance counters are built when CONV_SEQ_PERF_EN is defined.
module conv3x3_frame_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IMG_HEIGHT = 220,
    parameter int unsigned IMG_WIDTH  = 220
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    wgt_wr,
    input  logic [WADDR_W-1:0]      wgt_addr,
    input  logic [WEIGHT_WIDTH-1:0] wgt_data,
    input  logic [DATA_WIDTH-1:0]   pix_data,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    output logic                    conv_clr,
    output logic [DATA_WIDTH-1:0]   conv_data,
    output logic                    conv_valid,
    output logic [KERNEL_BUS_W-1:0] kernel_bus,
    input  logic                    conv_valid_out,
    output logic                    busy,
    output logic                    done,
`ifdef CONV_SEQ_PERF_EN
    output logic [31:0]             perf_cycles,
    output logic [31:0]             perf_stall,
`endif
    output logic                    cfg_err
);

    localparam int unsigned PIX_TOTAL = pix_total(IMG_HEIGHT, IMG_WIDTH);
    localparam int unsigned RES_TOTAL = res_total(IMG_HEIGHT, IMG_WIDTH);
    localparam int unsigned CNT_W     = $clog2(PIX_TOTAL + 1);
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIX_TOTAL);
    localparam logic [CNT_W-1:0] RES_LAST = CNT_W'(RES_TOTAL);

    seq_state_e             state_q;
    seq_state_e             state_nxt;
    logic [CNT_W-1:0]       pix_count_q;
    logic [CNT_W-1:0]       res_count_q;
    logic [CNT_W-1:0]       pix_count_nxt;
    logic [CNT_W-1:0]       res_count_nxt;
    logic [KERNEL_TAPS-1:0] mask;
    logic                   addr_ok_c;
    logic                   xfer_c;
    logic                   res_hit_c;
    logic                   cfg_err_nxt;

    conv_weight_bank u_bank (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wgt_wr && (state_q == IDLE)),
        .wr_addr    (wgt_addr),
        .wr_data    (wgt_data),
        .kernel_bus (kernel_bus),
        .mask       (mask),
        .addr_ok_c  (addr_ok_c)
    );

    assign xfer_c        = pix_valid && pix_ready;
    assign res_hit_c     = conv_valid_out && ((state_q == STREAM) || (state_q == DRAIN));
    assign pix_count_nxt = pix_count_q + CNT_W'(xfer_c);
    assign res_count_nxt = res_count_q + CNT_W'(res_hit_c);

    // Next-state and configuration-error decode; start checks the mask before any same-cycle write.
    always_comb begin
        state_nxt   = state_q;
        cfg_err_nxt = 1'b0;
        case (state_q)
            IDLE: begin
                if (wgt_wr && !addr_ok_c) cfg_err_nxt = 1'b1;
                if (start) begin
                    if (mask == '1) state_nxt   = CLEAR;
                    else            cfg_err_nxt = 1'b1;
                end
            end
            CLEAR:  state_nxt = STREAM;
            STREAM: if (xfer_c && (pix_count_nxt == PIX_LAST)) state_nxt = DRAIN;
            DRAIN:  if (res_count_nxt >= RES_LAST) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (wgt_wr && (state_q != IDLE)) cfg_err_nxt = 1'b1;
    end

    // State, counters and registered outputs; outputs follow the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pix_count_q <= '0;
            res_count_q <= '0;
            pix_ready   <= 1'b0;
            conv_clr    <= 1'b0;
            conv_data   <= '0;
            conv_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            pix_ready  <= (state_nxt == STREAM);
            conv_clr   <= (state_nxt == CLEAR);
            busy       <= (state_nxt == CLEAR) || (state_nxt == STREAM) || (state_nxt == DRAIN);
            done       <= (state_nxt == DONE);
            cfg_err    <= cfg_err_nxt;
            conv_valid <= xfer_c;
            if (xfer_c) conv_data <= pix_data;
            if (state_q == CLEAR) begin
                pix_count_q <= '0;
                res_count_q <= '0;
            end else begin
                pix_count_q <= pix_count_nxt;
                res_count_q <= res_count_nxt;
            end
        end
    end

`ifdef CONV_SEQ_PERF_EN
    // Frame cycle and source-stall counters, restarted on each accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if ((state_q == IDLE) && (state_nxt == CLEAR)) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (state_q != IDLE) begin
            if (perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
            if ((state_q == STREAM) && !pix_valid) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: doc/conv3x3_frame_sequencer.md
Name: conv3x3_frame_sequencer

Overview:
Controller that sequences one 3x3 stride-1 convolution engine frame by frame. It holds the nine 32-bit kernel weights in a register bank loaded over a simple write port. On start it clears the engine's line buffers, streams exactly IMG_HEIGHT*IMG_WIDTH pixels from a ready/valid source into the engine, and counts the (IMG_HEIGHT-2)*(IMG_WIDTH-2) results. It then signals done. It sits between the layer scheduler / pixel DMA and the convolution datapath.

Parameters:
DATA_WIDTH, 32, pixel and result width
IMG_HEIGHT, 220, input frame rows (>=3)
IMG_WIDTH, 220, input frame columns (>=3)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  begin frame (sampled in IDLE only)
wgt_wr  in  1  weight write strobe
wgt_addr  in  4  weight index 0..8, row-major
wgt_data  in  32  weight value
pix_data  in  DATA_WIDTH  source pixel
pix_valid  in  1  source pixel valid
pix_ready  out  1  sequencer accepts pixel
conv_clr  out  1  one-cycle flush of engine line buffers (ORed with rst at top level)
conv_data  out  DATA_WIDTH  pixel to engine
conv_valid  out  1  pixel valid to engine
kernel_bus  out  288  weights, index k at bits [32k+31:32k]
conv_valid_out  in  1  engine result valid
busy  out  1  high in CLEAR/STREAM/DRAIN
done  out  1  one-cycle pulse at frame end
cfg_err  out  1  one-cycle pulse on rejected write or start

Behaviour:
- Reset: all outputs 0; weight bank 0; weight-loaded mask 9'h000; state IDLE; counters 0.
- States: IDLE -> CLEAR -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE: wgt_wr with wgt_addr<=8 writes the weight and sets its mask bit. wgt_addr>=9 is ignored and pulses cfg_err. start with mask==9'h1FF moves to CLEAR. start with an incomplete mask stays in IDLE and pulses cfg_err. Simultaneous wgt_wr and start: the write takes effect first, and the start check uses the mask before the write.
- CLEAR: conv_clr=1 for exactly one cycle; pixel and result counters cleared; next STREAM.
- STREAM: pix_ready=1. A transfer is pix_valid&pix_ready. Each transfer registers into conv_data/conv_valid with 1-cycle latency; conv_valid=0 on cycles without a transfer. pix_count increments per transfer. On the transfer that brings pix_count to H*W: pix_ready drops the next cycle and the state becomes DRAIN.
- res_count increments on every conv_valid_out in STREAM or DRAIN, since results start before the input ends. conv_valid_out in IDLE, CLEAR or DONE is ignored.
- DRAIN: pix_ready=0. Leave for DONE when res_count reaches (H-2)*(W-2). If the final result arrives in the same cycle as the last pixel transfer, go to DONE directly after the last conv_valid has been issued.
- DONE: done=1 for one cycle, then IDLE. Weights and mask are retained, so back-to-back frames need only start.
- Weight writes outside IDLE are ignored and pulse cfg_err. kernel_bus is stable for the whole frame.
- Counter widths: $clog2(H*W+1); compare constants are computed at elaboration.
- rst mid-frame: return to IDLE immediately. Weights and mask are cleared. No done pulse.

Optional Feature:
CONV_SEQ_PERF_EN
- Defined: adds output perf_cycles (32 bits), counting cycles from CLEAR entry through DONE inclusive, saturating at 32'hFFFFFFFF. It is held until the next CLEAR and reset to 0 by rst. Also adds output perf_stall (32 bits), counting STREAM cycles with pix_valid=0.
- Not defined: these ports and counters are absent, with no other change.

Decomposition:
- Shared package conv_pkg: state enum (IDLE, CLEAR, STREAM, DRAIN, DONE), KERNEL_TAPS=9, WEIGHT_WIDTH=32, localparam helper for pixel and result totals.
- One sub-module, conv_weight_bank: 9x32 register file with the loaded mask, address check and flattened output.
- FSM and counters stay in the top module.

Test Plan:
- IMG 5x5: write weights 1..9, start, send 25 pixels with no bubbles -> conv_clr one pulse; 25 conv_valid pulses, each 1 cycle after its transfer; pix_ready low after the 25th transfer; done pulses after the 9th conv_valid_out; busy low the next cycle.
- Write only addresses 0..7, then start -> cfg_err pulse, state stays IDLE, busy=0. Write addr 8, start -> frame proceeds.
- wgt_wr addr 4 data 0xDEAD during STREAM -> cfg_err pulse; kernel_bus[159:128] unchanged. wgt_addr=12 in IDLE -> cfg_err, mask unchanged.
- Random pix_valid at 50% duty on 5x5 -> exactly 25 transfers accepted, the 26th offered pixel not taken, done after 9 results. With CONV_SEQ_PERF_EN, perf_stall equals the count of invalid STREAM cycles.
- rst asserted mid-STREAM after 10 pixels -> next cycle all outputs 0, mask 0, no done. Reload weights and start -> a full 25-pixel frame completes normally.
- Two back-to-back frames with no rewrite -> second start accepted, conv_clr pulses again, kernel_bus identical to the first frame.
